// File: rtl/adder_seq_ctrl.sv
// ---------------------------------------------------------------------------
// adder_seq_ctrl
//
// Purpose:
//   Byte-serial adder. A single 8-bit ripple-carry slice is reused over
//   NBYTES clock cycles, least significant byte first, to add two W-bit
//   operands (W = 8*NBYTES). A three-state FSM (IDLE, RUN, DONE) sequences
//   the slice and produces a one-cycle done pulse with the registered
//   result.
//
// Parameters:
//   NBYTES  operand width in bytes (2..8), default 4
//
// Ports:
//   clk    in   1   clock, all state updates on the rising edge
//   rst    in   1   synchronous active-high reset
//   start  in   1   request an operation; accepted only in IDLE
//   a      in   W   operand A, sampled on the accepting edge
//   b      in   W   operand B, sampled on the accepting edge
//   cin    in   1   carry into byte 0, sampled on the accepting edge
//   sub    in   1   (ADDER_SEQ_SUB_EN only) 1 = compute a-b, cin ignored
//   busy   out  1   high while byte slices are being processed (RUN)
//   done   out  1   one-cycle pulse; sum, cout and ovf are valid
//   sum    out  W   result, held until the next accepted start
//   cout   out  1   carry out of the MSB (for subtract: 1 = no borrow)
//   ovf    out  1   signed two's-complement overflow
//
// Configuration macro:
//   ADDER_SEQ_SUB_EN  when defined, adds the sub input and subtract mode.
// ---------------------------------------------------------------------------
module adder_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
`ifdef ADDER_SEQ_SUB_EN
    input  logic                  sub,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;        // effective B operand (inverted for subtract)
    logic [IDXW-1:0] r_idx;
    logic            r_carry;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_ovf;

    logic [7:0]      w_a_byte;
    logic [7:0]      w_b_byte;
    logic [7:0]      w_p;
    logic [7:0]      w_g;
    logic [8:0]      w_c;
    logic [7:0]      w_slice_sum;
    logic [W-1:0]    w_sum_next;
    logic [W-1:0]    w_b_eff;
    logic            w_cin_eff;

    // Operand conditioning at acceptance: subtract is a + ~b + 1.
`ifdef ADDER_SEQ_SUB_EN
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub ? 1'b1 : cin;
`else
    assign w_b_eff   = b;
    assign w_cin_eff = cin;
`endif

    // Byte selection for the current slice position and merge of the slice
    // result back into its byte lane. Loops use constant indices so each
    // lane becomes a simple mux.
    always_comb begin
        w_a_byte   = 8'd0;
        w_b_byte   = 8'd0;
        w_sum_next = r_sum;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_byte = r_a[8*i +: 8];
                w_b_byte = r_b[8*i +: 8];
                w_sum_next[8*i +: 8] = w_slice_sum;
            end
        end
    end

    // The shared 8-bit ripple-carry slice.
    assign w_c[0] = r_carry;
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_slice
            assign w_p[gi]         = w_a_byte[gi] ^ w_b_byte[gi];
            assign w_g[gi]         = w_a_byte[gi] & w_b_byte[gi];
            assign w_slice_sum[gi] = w_p[gi] ^ w_c[gi];
            assign w_c[gi+1]       = w_g[gi] | (w_p[gi] & w_c[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_eff;
                        r_carry <= w_cin_eff;
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_c[8];
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_state <= DONE;
                        r_cout  <= w_c[8];
                        // The slice's bit 7 is the final sum MSB on this edge.
                        r_ovf   <= (r_a[W-1] == r_b[W-1]) &&
                                   (w_slice_sum[7] != r_a[W-1]);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
